// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding, captured
// request record and the byte-lane merge used by read-modify-write stores.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam int         LANE_W    = 8;
  localparam int         NUM_LANES = 4;

  typedef struct packed {
    logic [31:0] addr;   // already word-aligned
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        id;
  } req_t;

  // Lanes with be set take the new data, the rest keep the current memory word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    if (be == BE_WORD) begin
      merged = new_word;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way request selector: round-robin against last_grant, or port 0 always
// wins ties when FIXED_PRIO is set.
module dm_rr_pick #(
  parameter int FIXED_PRIO = 0
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (valid1)      grant_id = 1'b1;
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the word-only data memory between the MEM stage (port 0) and the debug
// loader (port 1); sub-word stores become read-modify-write in the ACCESS cycle.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic [3:0]        req0_be,
  input  logic [31:0]       req0_wdata,
  output logic              resp0_valid,
  output logic [31:0]       resp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  input  logic [3:0]        req1_be,
  input  logic [31:0]       req1_wdata,
  output logic              resp1_valid,
  output logic [31:0]       resp1_rdata,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant_valid, grant_id, accept;
  req_t              sel_req, cur;
  logic [31:0]       addr0_ext, addr1_ext;
  logic [31:0]       maddr_q, mwdata_q, acc_wdata;
  logic [1:0][31:0]  rdata_q;
  logic              unused_addr_lsbs;

  dm_rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign addr0_ext        = 32'(req0_addr);
  assign addr1_ext        = 32'(req1_addr);
  assign unused_addr_lsbs = ^{addr0_ext[1:0], addr1_ext[1:0]};

  assign accept    = (state == ST_IDLE) && grant_valid && !reset;
  assign acc_wdata = lane_merge(mem_rdata, cur.wdata, cur.be);

  always_comb begin
    sel_req = '{addr: {addr0_ext[31:2], 2'b00}, we: req0_we, be: req0_be,
                wdata: req0_wdata, id: 1'b0};
    if (grant_id)
      sel_req = '{addr: {addr1_ext[31:2], 2'b00}, we: req1_we, be: req1_be,
                  wdata: req1_wdata, id: 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates the combinational strobes so a dropped transaction never writes.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = maddr_q;
    mem_wdata   = mwdata_q;
    case (state)
      ST_IDLE: begin
        req0_ready = accept && !grant_id;
        req1_ready = accept &&  grant_id;
      end
      ST_ACCESS: begin
        mem_addr  = cur.addr;
        mem_wdata = acc_wdata;
        mem_we    = cur.we && (|cur.be) && !reset;
      end
      ST_RESP: begin
        resp0_valid = !reset && !cur.id;
        resp1_valid = !reset &&  cur.id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      cur        <= '0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        cur        <= sel_req;
        last_grant <= grant_id;
      end
      if (state == ST_ACCESS) begin
        maddr_q         <= cur.addr;
        mwdata_q        <= acc_wdata;
        rdata_q[cur.id] <= mem_rdata;
      end
    end
  end

  assign resp0_rdata = rdata_q[0];
  assign resp1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grants, memory traffic
// and responses; a negedge monitor compares the DUT against it.
module tb_dm_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req0_ready, req0_we, resp0_valid;
  logic [31:0] req0_addr, req0_wdata, resp0_rdata;
  logic [3:0]  req0_be;
  logic        req1_valid, req1_ready, req1_we, resp1_valid;
  logic [31:0] req1_addr, req1_wdata, resp1_rdata;
  logic [3:0]  req1_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:63] = '{default: '0};
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  dm_port_arbiter #(.FIXED_PRIO(0), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_be(req0_be), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_be(req1_be), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance with both ports requesting all the time.
  logic        one = 1'b1, zero1 = 1'b0;
  logic [3:0]  zero4 = '0;
  logic [31:0] zero32 = '0;
  logic        fp_r0, fp_r1, fp_rv0, fp_rv1, fp_mwe;
  logic [31:0] fp_rd0, fp_rd1, fp_maddr, fp_mwd;

  dm_port_arbiter #(.FIXED_PRIO(1), .ADDR_W(32)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(one), .req0_ready(fp_r0), .req0_addr(zero32),
    .req0_we(zero1), .req0_be(zero4), .req0_wdata(zero32),
    .resp0_valid(fp_rv0), .resp0_rdata(fp_rd0),
    .req1_valid(one), .req1_ready(fp_r1), .req1_addr(zero32),
    .req1_we(zero1), .req1_be(zero4), .req1_wdata(zero32),
    .resp1_valid(fp_rv1), .resp1_rdata(fp_rd1),
    .mem_addr(fp_maddr), .mem_wdata(fp_mwd), .mem_we(fp_mwe), .mem_rdata(zero32)
  );

  int checks = 0, errors = 0, cyc = 0, fp_grants = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] rdata; int due; } exp_t;
  typedef struct { int port; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } txn_t;
  typedef struct { int c; int p; } gl_t;

  exp_t        q [2][$];
  gl_t         glog [$];
  txn_t        pend;
  int          busy = 0, m_last = 1;
  logic [31:0] ref_mem [0:63] = '{default: '0};
  logic [31:0] last_maddr = '0;

  always @(negedge clk) begin
    logic [31:0] old_w, new_w, rd;
    logic [1:0]  rdy;
    logic        rv, v0, v1, wr;
    int          idx, w;
    exp_t        e;
    if (reset) begin
      if (busy == 2) chk("reset_blocks_write", 32'(mem_we), 32'd0);
      busy = 0; m_last = 1; last_maddr = '0;
      q[0].delete(); q[1].delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        rv = (p == 1) ? resp1_valid : resp0_valid;
        rd = (p == 1) ? resp1_rdata : resp0_rdata;
        if (rv) begin
          if (q[p].size() == 0) begin
            checks++; errors++;
            $display("FAIL resp%0d_unexpected: pulse with nothing outstanding (cycle %0d)", p, cyc);
          end else begin
            e = q[p].pop_front();
            chk($sformatf("resp%0d_rdata", p), rd, e.rdata);
            chk($sformatf("resp%0d_cycle", p), cyc, e.due);
          end
        end else if (q[p].size() > 0 && q[p][0].due < cyc) begin
          checks++; errors++;
          $display("FAIL resp%0d_missing: none by cycle %0d, required at %0d", p, cyc, q[p][0].due);
          void'(q[p].pop_front());
        end
      end
      rdy = {req1_ready, req0_ready};
      v0  = req0_valid;
      v1  = req1_valid;
      if (busy == 2) begin
        idx   = int'(pend.addr[7:2]);
        old_w = ref_mem[idx];
        new_w = old_w;
        for (int i = 0; i < 4; i++) if (pend.be[i]) new_w[8*i +: 8] = pend.wdata[8*i +: 8];
        wr = pend.we && (pend.be != 4'b0000);
        chk("mem_addr", mem_addr, {pend.addr[31:2], 2'b00});
        chk("mem_we", 32'(mem_we), 32'(wr));
        if (wr) begin
          chk("mem_wdata", mem_wdata, new_w);
          ref_mem[idx] = new_w;
        end
        e.rdata = old_w; e.due = cyc + 1;
        q[pend.port].push_back(e);
        last_maddr = {pend.addr[31:2], 2'b00};
        if (v0 || v1) chk("ready_when_busy", 32'(rdy), 32'd0);
        busy = 1;
      end else if (busy == 1) begin
        chk("mem_we_outside_access", 32'(mem_we), 32'd0);
        chk("mem_addr_hold", mem_addr, last_maddr);
        if (v0 || v1) chk("ready_when_busy", 32'(rdy), 32'd0);
        busy = 0;
      end else if (v0 || v1) begin
        w = (v0 && v1) ? 1 - m_last : (v0 ? 0 : 1);
        chk("grant", 32'(rdy), (w == 0) ? 32'd1 : 32'd2);
        if (w == 0) pend = '{port: 0, addr: req0_addr, we: req0_we, be: req0_be, wdata: req0_wdata};
        else        pend = '{port: 1, addr: req1_addr, we: req1_we, be: req1_be, wdata: req1_wdata};
        glog.push_back('{c: cyc, p: w});
        m_last = w;
        busy   = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (fp_r1) begin
        checks++; errors++;
        $display("FAIL fixed_prio_grant: port 1 granted, required port 0 (cycle %0d)", cyc);
      end
      if (fp_r0) fp_grants++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input logic v, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_addr = a; req0_we = we; req0_be = be; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_addr = a; req1_we = we; req1_be = be; req1_wdata = wd;
    end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    @(posedge clk); #1;
    drive(p, 1'b1, a, we, be, wd);
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = (p == 1) ? req1_ready : req0_ready;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: port %0d not accepted within 100 cycles", p);
    end
    @(posedge clk); #1;
    // Scramble the bus after accept: the arbiter must work from its captured copy.
    drive(p, 1'b0, $urandom, 1'($urandom), 4'($urandom), $urandom);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if ((p == 1) ? resp1_valid : resp0_valid) begin
        got = 1;
        rd  = (p == 1) ? resp1_rdata : resp0_rdata;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout: port %0d saw no response within 10 cycles", p);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int c0, pulses;
    int exp_port [4] = '{0, 1, 0, 1};

    reset = 1'b1;
    drive(0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp0_rdata", resp0_rdata, 32'd0);
    chk("rst_resp1_rdata", resp1_rdata, 32'd0);

    // word write then read back
    issue(0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, rd);
    issue(0, 32'h10, 1'b0, 4'b1111, 32'h0, rd);
    chk("word_readback", rd, 32'hDEADBEEF);

    // byte store via read-modify-write from port 1
    issue(0, 32'h20, 1'b1, 4'b1111, 32'h11223344, rd);
    issue(1, 32'h20, 1'b1, 4'b0100, 32'h00AA0000, rd);
    chk("rmw_old_word", rd, 32'h11223344);
    chk("rmw_mem_word", mem[8], 32'h11AA3344);
    issue(1, 32'h20, 1'b0, 4'b1111, 32'h0, rd);
    chk("rmw_readback", rd, 32'h11AA3344);

    // be = 0 write: responds but leaves memory untouched
    issue(0, 32'h30, 1'b1, 4'b1111, 32'h00000055, rd);
    issue(1, 32'h30, 1'b1, 4'b0000, 32'hFFFFFFFF, rd);
    chk("be0_old_word", rd, 32'h00000055);
    chk("be0_mem_word", mem[12], 32'h00000055);

    // misaligned address reads the containing word
    issue(1, 32'h44, 1'b1, 4'b1111, 32'hCAFEF00D, rd);
    issue(0, 32'h47, 1'b0, 4'b1111, 32'h0, rd);
    chk("misaligned_read", rd, 32'hCAFEF00D);

    // reset during the ACCESS cycle of a write to 0x50
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h50, 1'b1, 4'b1111, 32'h12345678);
    for (int k = 0; k < 20 && !req1_ready; k++) @(negedge clk);
    @(posedge clk); #1;
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp0_valid || resp1_valid) pulses++;
    end
    chk("reset_drop_no_resp", pulses, 32'd0);
    chk("reset_drop_mem", mem[20], 32'd0);
    issue(0, 32'h50, 1'b0, 4'b1111, 32'h0, rd);
    chk("reset_drop_readback", rd, 32'd0);

    // both ports requesting continuously from reset
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b1, 32'h10, 1'b0, 4'b1111, '0);
    drive(1, 1'b1, 32'h20, 1'b0, 4'b1111, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    glog.delete();
    @(negedge clk);
    c0 = cyc;
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
    chk("contention_grants", glog.size(), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      chk($sformatf("contention_port%0d", i), glog[i].p, exp_port[i]);
      chk($sformatf("contention_cycle%0d", i), glog[i].c - c0, 3 * i);
    end

    // randomized traffic on both ports concurrently
    fork
      for (int n = 0; n < 40; n++) begin
        logic [31:0] r0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(0, 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
              1'($urandom), 4'($urandom), $urandom, r0);
      end
      for (int n = 0; n < 40; n++) begin
        logic [31:0] r1;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        issue(1, 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
              1'($urandom), 4'($urandom), $urandom, r1);
      end
    join
    repeat (5) @(negedge clk);

    for (int i = 0; i < 64; i++) chk($sformatf("mem_word%0d", i), mem[i], ref_mem[i]);
    chk("outstanding_port0", q[0].size(), 32'd0);
    chk("outstanding_port1", q[1].size(), 32'd0);
    chk("fixed_prio_progress", 32'(fp_grants > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
